// File: rtl/amm_perf_meter_pkg.sv
// Shared types and helpers for the AMM performance meter.
package measure_pkg;

  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } addr_type_t;

  localparam int unsigned SAT_MAX_W    = 64;
  localparam int unsigned POPCNT_MAX_W = 256;

  // Add two values and clamp the result to the all-ones value of a w-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                   input logic [SAT_MAX_W-1:0] b,
                                                   input int unsigned          w);
    logic [SAT_MAX_W:0] s;
    logic [SAT_MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    return (s > lim) ? lim[SAT_MAX_W-1:0] : s[SAT_MAX_W-1:0];
  endfunction

  // Number of set bits.
  function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POPCNT_MAX_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/amm_perf_meter_if.sv
// Avalon-MM request/response signals observed by the performance meter.
interface amm_perf_meter_if #(
  parameter int unsigned AMM_DATA_W  = 128,
  parameter int unsigned AMM_BURST_W = 11
);
  localparam int unsigned BYTE_PER_WORD = AMM_DATA_W / 8;

  logic                     read;
  logic                     write;
  logic                     waitrequest;
  logic                     readdatavalid;
  logic [AMM_BURST_W-1:0]   burstcount;
  logic [BYTE_PER_WORD-1:0] byteenable;

  modport master (
    output read, write, burstcount, byteenable,
    input  waitrequest, readdatavalid
  );

  modport slave (
    input  read, write, burstcount, byteenable,
    output waitrequest, readdatavalid
  );

  // Passive tap: every signal is an input.
  modport monitor (
    input read, write, waitrequest, readdatavalid, burstcount, byteenable
  );

endinterface

// File: rtl/amm_perf_meter_rd_trace_queue.sv
// Circular buffer of outstanding read bursts: {accept timestamp, remaining beats, first-beat flag}.
module rd_trace_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [TS_W-1:0]  push_ts_i,
  input  logic [LEN_W-1:0] push_len_i,
  input  logic             beat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [TS_W-1:0]  head_ts_o,
  output logic [LEN_W-1:0] head_rem_o,
  output logic             head_first_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [TS_W-1:0]  ts_q  [DEPTH];
  logic [LEN_W-1:0] rem_q [DEPTH];
  logic [DEPTH-1:0] first_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o       = (count_q == FULL_CNT);
  assign empty_o      = (count_q == '0);
  assign pop_ok       = pop_i & ~empty_o;
  assign push_ok      = push_i & (~full_o | pop_ok);
  assign head_ts_o    = ts_q[rd_ptr_q];
  assign head_rem_o   = rem_q[rd_ptr_q];
  assign head_first_o = first_q[rd_ptr_q];

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Entry and pointer state; when full, a push lands in the slot being popped and overrides the head update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      first_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ts_q[i]  <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (beat_i && !empty_o) begin
        rem_q[rd_ptr_q]   <= rem_q[rd_ptr_q] - 1'b1;
        first_q[rd_ptr_q] <= 1'b0;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        ts_q[wr_ptr_q]    <= push_ts_i;
        rem_q[wr_ptr_q]   <= push_len_i;
        first_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/amm_perf_meter.sv
// Passive Avalon-MM performance meter: first-word read latency min/max/sum, traffic and busy counters.
// Optional latency histogram is built when MEASURE_HISTOGRAM_EN is defined; otherwise hist_o is tied to zero.
module amm_perf_meter
  import measure_pkg::*;
#(
  parameter int unsigned AMM_DATA_W      = 128,
  parameter int unsigned AMM_BURST_W     = 11,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DELAY_W         = 16,
  parameter int unsigned CNT_W           = 32,
  parameter addr_type_t  ADDR_TYPE       = BYTE,
  parameter int unsigned HIST_BINS       = 16,
  parameter int unsigned HIST_SHIFT      = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  amm_perf_meter_if.monitor               amm,
  input  logic                            reset_module_i,
  output logic                            busy_o,
  output logic                            error_o,
  output logic [DELAY_W-1:0]              min_delay_o,
  output logic [DELAY_W-1:0]              max_delay_o,
  output logic [CNT_W-1:0]                sum_delay_o,
  output logic [CNT_W-1:0]                rd_trans_cnt_o,
  output logic [CNT_W-1:0]                rd_words_cnt_o,
  output logic [CNT_W-1:0]                rd_ticks_o,
  output logic [CNT_W-1:0]                wr_ticks_o,
  output logic [CNT_W-1:0]                wr_units_cnt_o,
  output logic [HIST_BINS-1:0][CNT_W-1:0] hist_o
);

  localparam int unsigned BYTE_PER_WORD = AMM_DATA_W / 8;
  localparam int unsigned PC_W          = $clog2(BYTE_PER_WORD + 1);

  logic [BYTE_PER_WORD-1:0] be;
  logic                     rd_acc, wr_acc, beat_hit;
  logic                     q_push, q_pop, q_full, q_empty, head_first;
  logic [DELAY_W-1:0]       head_ts, delay;
  logic [AMM_BURST_W-1:0]   head_rem, push_len;

  logic [DELAY_W-1:0] ts_q, ts_d;
  logic               lat_vld_q, lat_vld_d;
  logic [DELAY_W-1:0] lat_q, lat_d;
  logic               trans_inc_q, trans_inc_d;
  logic [PC_W-1:0]    wr_pc_q, wr_pc_d;

  logic [DELAY_W-1:0] min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0]   sum_q, sum_d, trans_q, trans_d, rd_words_q, rd_words_d;
  logic [CNT_W-1:0]   rd_ticks_q, rd_ticks_d, wr_ticks_q, wr_ticks_d, wr_units_q, wr_units_d;
  logic               error_q, error_d;

  assign be       = amm.byteenable;
  assign rd_acc   = amm.read & ~amm.waitrequest;
  assign wr_acc   = amm.write & ~amm.waitrequest;
  assign beat_hit = amm.readdatavalid & ~q_empty;
  assign q_pop    = beat_hit & (head_rem <= AMM_BURST_W'(1));
  assign q_push   = rd_acc & (~q_full | q_pop);
  assign push_len = (amm.burstcount == '0) ? AMM_BURST_W'(1) : amm.burstcount;
  assign delay    = ts_q - head_ts;

  rd_trace_queue #(
    .DEPTH (MAX_OUTSTANDING),
    .TS_W  (DELAY_W),
    .LEN_W (AMM_BURST_W)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_i       (q_push),
    .push_ts_i    (ts_q),
    .push_len_i   (push_len),
    .beat_i       (beat_hit),
    .pop_i        (q_pop),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_ts_o    (head_ts),
    .head_rem_o   (head_rem),
    .head_first_o (head_first)
  );

  // Free-running timestamp plus one-cycle staging of latency samples, completions and write units.
  always_comb begin
    ts_d        = ts_q + 1'b1;
    lat_vld_d   = beat_hit & head_first;
    lat_d       = delay;
    trans_inc_d = q_pop;
    wr_pc_d     = wr_acc ? PC_W'(popcount(POPCNT_MAX_W'(be))) : '0;
  end

  // Staging registers are not touched by reset_module_i: they carry in-flight measurements.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ts_q        <= '0;
      lat_vld_q   <= 1'b0;
      lat_q       <= '0;
      trans_inc_q <= 1'b0;
      wr_pc_q     <= '0;
    end else begin
      ts_q        <= ts_d;
      lat_vld_q   <= lat_vld_d;
      lat_q       <= lat_d;
      trans_inc_q <= trans_inc_d;
      wr_pc_q     <= wr_pc_d;
    end
  end

  // Statistics next-state: saturating counters, latency extremes and sticky protocol error.
  always_comb begin
    min_d      = min_q;
    max_d      = max_q;
    sum_d      = sum_q;
    trans_d    = trans_q;
    rd_words_d = rd_words_q;
    rd_ticks_d = rd_ticks_q;
    wr_ticks_d = wr_ticks_q;
    wr_units_d = wr_units_q;
    error_d    = error_q;
    if (lat_vld_q) begin
      sum_d = CNT_W'(sat_add(SAT_MAX_W'(sum_q), SAT_MAX_W'(lat_q), CNT_W));
      if (lat_q < min_q) min_d = lat_q;
      if (lat_q > max_q) max_d = lat_q;
    end
    if (trans_inc_q) trans_d = CNT_W'(sat_add(SAT_MAX_W'(trans_q), SAT_MAX_W'(1), CNT_W));
    if (amm.readdatavalid) rd_words_d = CNT_W'(sat_add(SAT_MAX_W'(rd_words_q), SAT_MAX_W'(1), CNT_W));
    if (busy_o || amm.read) rd_ticks_d = CNT_W'(sat_add(SAT_MAX_W'(rd_ticks_q), SAT_MAX_W'(1), CNT_W));
    if (amm.write) wr_ticks_d = CNT_W'(sat_add(SAT_MAX_W'(wr_ticks_q), SAT_MAX_W'(1), CNT_W));
    if (ADDR_TYPE == BYTE) begin
      wr_units_d = CNT_W'(sat_add(SAT_MAX_W'(wr_units_q), SAT_MAX_W'(wr_pc_q), CNT_W));
    end else if (wr_acc) begin
      wr_units_d = CNT_W'(sat_add(SAT_MAX_W'(wr_units_q), SAT_MAX_W'(1), CNT_W));
    end
    if ((rd_acc && q_full && !q_pop) || (amm.readdatavalid && q_empty) ||
        (rd_acc && amm.burstcount == '0)) begin
      error_d = 1'b1;
    end
    if (reset_module_i) begin
      min_d      = '1;
      max_d      = '0;
      sum_d      = '0;
      trans_d    = '0;
      rd_words_d = '0;
      rd_ticks_d = '0;
      wr_ticks_d = '0;
      wr_units_d = '0;
      error_d    = 1'b0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      min_q      <= '1;
      max_q      <= '0;
      sum_q      <= '0;
      trans_q    <= '0;
      rd_words_q <= '0;
      rd_ticks_q <= '0;
      wr_ticks_q <= '0;
      wr_units_q <= '0;
      error_q    <= 1'b0;
    end else begin
      min_q      <= min_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      trans_q    <= trans_d;
      rd_words_q <= rd_words_d;
      rd_ticks_q <= rd_ticks_d;
      wr_ticks_q <= wr_ticks_d;
      wr_units_q <= wr_units_d;
      error_q    <= error_d;
    end
  end

  assign busy_o         = ~q_empty;
  assign error_o        = error_q;
  assign min_delay_o    = min_q;
  assign max_delay_o    = max_q;
  assign sum_delay_o    = sum_q;
  assign rd_trans_cnt_o = trans_q;
  assign rd_words_cnt_o = rd_words_q;
  assign rd_ticks_o     = rd_ticks_q;
  assign wr_ticks_o     = wr_ticks_q;
  assign wr_units_cnt_o = wr_units_q;

`ifdef MEASURE_HISTOGRAM_EN
  localparam int unsigned BIN_W = (HIST_BINS > 1) ? $clog2(HIST_BINS) : 1;

  logic [HIST_BINS-1:0][CNT_W-1:0] hist_q, hist_d;
  logic [DELAY_W-1:0]              bin_raw;
  logic [BIN_W-1:0]                bin_idx;

  // Histogram next-state: one saturating increment per latency sample, last bin catches the tail.
  always_comb begin
    bin_raw = lat_q >> HIST_SHIFT;
    bin_idx = (bin_raw >= DELAY_W'(HIST_BINS - 1)) ? BIN_W'(HIST_BINS - 1) : BIN_W'(bin_raw);
    hist_d  = hist_q;
    if (lat_vld_q) begin
      hist_d[bin_idx] = CNT_W'(sat_add(SAT_MAX_W'(hist_q[bin_idx]), SAT_MAX_W'(1), CNT_W));
    end
    if (reset_module_i) hist_d = '0;
  end

  // Histogram bins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist_o = hist_q;
`else
  assign hist_o = '0;
`endif

endmodule

// File: tb/tb_amm_perf_meter.sv
// Directed self-checking bench for amm_perf_meter (BYTE instance plus a WORD instance for write units).
module tb_amm_perf_meter;
  import measure_pkg::*;

  localparam int unsigned DW  = 128;
  localparam int unsigned BW  = 11;
  localparam int unsigned CW  = 32;
  localparam int unsigned DLW = 16;
  localparam int unsigned HB  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reset_module = 1'b0;

  amm_perf_meter_if #(.AMM_DATA_W(DW), .AMM_BURST_W(BW)) bus ();

  logic                    busy, error;
  logic [DLW-1:0]          min_dl, max_dl;
  logic [CW-1:0]           sum_dl, trans, words, rticks, wticks, units;
  logic [HB-1:0][CW-1:0]   hist;

  logic                    w_busy, w_error;
  logic [DLW-1:0]          w_min_dl, w_max_dl;
  logic [CW-1:0]           w_sum_dl, w_trans, w_words, w_rticks, w_wticks, w_units;
  logic [HB-1:0][CW-1:0]   w_hist;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  amm_perf_meter #(
    .AMM_DATA_W(DW), .AMM_BURST_W(BW), .MAX_OUTSTANDING(8), .DELAY_W(DLW), .CNT_W(CW),
    .ADDR_TYPE(BYTE), .HIST_BINS(HB), .HIST_SHIFT(2)
  ) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .amm(bus), .reset_module_i(reset_module),
    .busy_o(busy), .error_o(error), .min_delay_o(min_dl), .max_delay_o(max_dl),
    .sum_delay_o(sum_dl), .rd_trans_cnt_o(trans), .rd_words_cnt_o(words),
    .rd_ticks_o(rticks), .wr_ticks_o(wticks), .wr_units_cnt_o(units), .hist_o(hist)
  );

  amm_perf_meter #(
    .AMM_DATA_W(DW), .AMM_BURST_W(BW), .MAX_OUTSTANDING(8), .DELAY_W(DLW), .CNT_W(CW),
    .ADDR_TYPE(WORD), .HIST_BINS(HB), .HIST_SHIFT(2)
  ) u_dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .amm(bus), .reset_module_i(reset_module),
    .busy_o(w_busy), .error_o(w_error), .min_delay_o(w_min_dl), .max_delay_o(w_max_dl),
    .sum_delay_o(w_sum_dl), .rd_trans_cnt_o(w_trans), .rd_words_cnt_o(w_words),
    .rd_ticks_o(w_rticks), .wr_ticks_o(w_wticks), .wr_units_cnt_o(w_units), .hist_o(w_hist)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_stats();
    reset_module = 1'b1;
    tick(1);
    reset_module = 1'b0;
  endtask

  // One read burst accepted now; its beats start 'lat' cycles after the accept edge.
  task automatic rd_burst(input logic [BW-1:0] bc, input int unsigned lat, input int unsigned beats);
    bus.read = 1'b1;
    bus.burstcount = bc;
    tick(1);
    bus.read = 1'b0;
    bus.burstcount = '0;
    tick(lat - 1);
    bus.readdatavalid = 1'b1;
    tick(beats);
    bus.readdatavalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.waitrequest = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.burstcount = '0;
    bus.byteenable = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_error",  64'(error),  64'd0);
    chk("rst_min",    64'(min_dl), 64'hFFFF);
    chk("rst_max",    64'(max_dl), 64'd0);
    chk("rst_sum",    64'(sum_dl), 64'd0);
    chk("rst_trans",  64'(trans),  64'd0);
    chk("rst_words",  64'(words),  64'd0);
    chk("rst_units",  64'(units),  64'd0);
    chk("rst_hist",   64'(|hist),  64'd0);

    // 1: burst of 4, data at t+5..t+8
    rd_burst(11'd4, 5, 4);
    tick(1);
    chk("t1_min",    64'(min_dl), 64'd5);
    chk("t1_max",    64'(max_dl), 64'd5);
    chk("t1_sum",    64'(sum_dl), 64'd5);
    chk("t1_trans",  64'(trans),  64'd1);
    chk("t1_words",  64'(words),  64'd4);
    chk("t1_rticks", 64'(rticks), 64'd9);
    chk("t1_busy",   64'(busy),   64'd0);
    chk("t1_error",  64'(error),  64'd0);

    // 2: 8 back-to-back single-beat reads, latencies 3..10
    clear_stats();
    for (int unsigned c = 0; c < 18; c++) begin
      bus.read = (c < 8);
      bus.burstcount = 11'd1;
      bus.readdatavalid = (c >= 3 && c % 2 == 1);
      tick(1);
      if (c == 16) chk("t2_busy_before_last", 64'(busy), 64'd1);
    end
    bus.read = 1'b0;
    bus.readdatavalid = 1'b0;
    chk("t2_busy_after_last", 64'(busy), 64'd0);
    tick(1);
    chk("t2_min",   64'(min_dl), 64'd3);
    chk("t2_max",   64'(max_dl), 64'd10);
    chk("t2_sum",   64'(sum_dl), 64'd52);
    chk("t2_trans", 64'(trans),  64'd8);
    chk("t2_words", 64'(words),  64'd8);
    chk("t2_error", 64'(error),  64'd0);

    // 3: overflow while full, then push+pop at full
    clear_stats();
    bus.read = 1'b1;
    bus.burstcount = 11'd1;
    tick(8);
    chk("t3_full_noerr", 64'(error), 64'd0);
    tick(1);
    bus.read = 1'b0;
    chk("t3_overflow_err", 64'(error), 64'd1);
    clear_stats();
    chk("t3_err_cleared", 64'(error), 64'd0);
    bus.read = 1'b1;
    bus.readdatavalid = 1'b1;
    tick(1);
    bus.read = 1'b0;
    chk("t3_pushpop_noerr", 64'(error), 64'd0);
    tick(8);
    bus.readdatavalid = 1'b0;
    tick(1);
    chk("t3_drain_error", 64'(error), 64'd0);
    chk("t3_drain_busy",  64'(busy),  64'd0);
    chk("t3_trans",       64'(trans), 64'd9);
    chk("t3_words",       64'(words), 64'd9);

    // 4: reset_module with two bursts in flight
    clear_stats();
    bus.read = 1'b1;
    bus.burstcount = 11'd2;
    tick(1);
    bus.burstcount = 11'd1;
    tick(1);
    bus.read = 1'b0;
    bus.burstcount = '0;
    reset_module = 1'b1;
    tick(1);
    reset_module = 1'b0;
    chk("t4_clr_min",    64'(min_dl), 64'hFFFF);
    chk("t4_clr_sum",    64'(sum_dl), 64'd0);
    chk("t4_clr_rticks", 64'(rticks), 64'd0);
    chk("t4_clr_busy",   64'(busy),   64'd1);
    tick(1);
    bus.readdatavalid = 1'b1;
    tick(3);
    bus.readdatavalid = 1'b0;
    tick(1);
    chk("t4_min",    64'(min_dl), 64'd4);
    chk("t4_max",    64'(max_dl), 64'd5);
    chk("t4_sum",    64'(sum_dl), 64'd9);
    chk("t4_trans",  64'(trans),  64'd2);
    chk("t4_words",  64'(words),  64'd3);
    chk("t4_rticks", 64'(rticks), 64'd4);
    chk("t4_error",  64'(error),  64'd0);

    // 5: write units, BYTE vs WORD, last write stalled by waitrequest
    clear_stats();
    bus.write = 1'b1;
    bus.byteenable = 16'hFFFF;
    tick(1);
    bus.byteenable = 16'h00FF;
    tick(1);
    bus.byteenable = 16'h0001;
    tick(1);
    bus.waitrequest = 1'b1;
    bus.byteenable = 16'hFFFF;
    tick(1);
    bus.write = 1'b0;
    bus.waitrequest = 1'b0;
    bus.byteenable = '0;
    tick(1);
    chk("t5_byte_units", 64'(units),   64'd25);
    chk("t5_word_units", 64'(w_units), 64'd3);
    chk("t5_wticks",     64'(wticks),  64'd4);

    // 6: saturation of rd_words plus stray beats on an empty queue
    clear_stats();
    force u_dut.rd_words_q = 32'hFFFF_FFFE;
    tick(1);
    release u_dut.rd_words_q;
    chk("t6_words_preset", 64'(words), 64'hFFFF_FFFE);
    bus.readdatavalid = 1'b1;
    tick(3);
    bus.readdatavalid = 1'b0;
    chk("t6_words_sat", 64'(words), 64'hFFFF_FFFF);
    chk("t6_stray_err", 64'(error), 64'd1);

    // 7: latency 5 and 500 (histogram bins 1 and 15 when built)
    clear_stats();
    rd_burst(11'd1, 5, 1);
    rd_burst(11'd1, 500, 1);
    tick(1);
    chk("t7_min", 64'(min_dl), 64'd5);
    chk("t7_max", 64'(max_dl), 64'd500);
    chk("t7_sum", 64'(sum_dl), 64'd505);
`ifdef MEASURE_HISTOGRAM_EN
    chk("t7_hist_bin0",  64'(hist[0]),  64'd0);
    chk("t7_hist_bin1",  64'(hist[1]),  64'd1);
    chk("t7_hist_bin15", 64'(hist[15]), 64'd1);
`else
    chk("t7_hist_off", 64'(|hist), 64'd0);
`endif

    // 8: async reset mid-burst, then a stray beat
    bus.read = 1'b1;
    bus.burstcount = 11'd2;
    tick(1);
    bus.read = 1'b0;
    bus.burstcount = '0;
    tick(1);
    chk("t8_busy_inflight", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t8_busy_reset",  64'(busy),   64'd0);
    chk("t8_min_reset",   64'(min_dl), 64'hFFFF);
    chk("t8_error_reset", 64'(error),  64'd0);
    bus.readdatavalid = 1'b1;
    tick(1);
    bus.readdatavalid = 1'b0;
    chk("t8_stray_err",   64'(error), 64'd1);
    chk("t8_stray_words", 64'(words), 64'd1);
    tick(1);
    chk("t8_trans", 64'(trans), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
